regfile_write_arbiter: RTL and testbench

- Shares the register file's single write port (we / a2 / wd) between two independent write requesters, for example ALU writeback and load return.
- Each requester gets a DEPTH-entry queue with a valid/ready handshake.
- A round-robin arbiter drains the queue heads into the write port, one write per cycle.
- A hazard query reports whether a given register still has a queued, unretired write.

---
 rtl/regfile_write_arbiter_if.sv | 40 ++++
 rtl/regfile_write_arbiter.sv | 90 +++++++++
 tb/tb_regfile_write_arbiter.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_write_arbiter_if.sv
// regfile_write_arbiter_if: bundle of the two requester handshakes, the register file write port and the hazard query
// Ports (as signals): req0/req1 valid, ready, addr, data; we, a2, wd, grant; query_addr, query_hit.
// master = requester/register-file side, slave = arbiter side.
interface regfile_write_arbiter_if #(
    parameter int WIDTH = 8,
    parameter int ADDRESS_WIDTH = 8
);
    logic                     req0_valid;
    logic                     req0_ready;
    logic [ADDRESS_WIDTH-1:0] req0_addr;
    logic [WIDTH-1:0]         req0_data;
    logic                     req1_valid;
    logic                     req1_ready;
    logic [ADDRESS_WIDTH-1:0] req1_addr;
    logic [WIDTH-1:0]         req1_data;
    logic                     we;
    logic [ADDRESS_WIDTH-1:0] a2;
    logic [WIDTH-1:0]         wd;
    logic                     grant;
    logic [ADDRESS_WIDTH-1:0] query_addr;
    logic                     query_hit;

    modport master (
        output req0_valid, req0_addr, req0_data,
        output req1_valid, req1_addr, req1_data,
        output query_addr,
        input  req0_ready, req1_ready,
        input  we, a2, wd, grant,
        input  query_hit
    );

    modport slave (
        input  req0_valid, req0_addr, req0_data,
        input  req1_valid, req1_addr, req1_data,
        input  query_addr,
        output req0_ready, req1_ready,
        output we, a2, wd, grant,
        output query_hit
    );
endinterface

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: two DEPTH-entry write queues drained round-robin into a single register file write port
// Ports: clock (rising edge), reset_n (async, active-low), bus (slave): req0/req1 valid/ready/addr/data in,
// we/a2/wd/grant write port out, query_addr in and query_hit out for the pending-write hazard lookup.
module regfile_write_arbiter #(
    parameter int WIDTH = 8,
    parameter int ADDRESS_WIDTH = 8,
    parameter int DEPTH = 2
) (
    input logic                   clock,
    input logic                   reset_n,
    regfile_write_arbiter_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL = (PW + 1)'(DEPTH);

    logic [ADDRESS_WIDTH-1:0] q_addr [2][DEPTH];
    logic [WIDTH-1:0]         q_data [2][DEPTH];
    logic [PW-1:0]            rp [2];
    logic [PW-1:0]            wp [2];
    logic [PW:0]              cnt [2];
    logic                     rr;
    logic [ADDRESS_WIDTH-1:0] in_addr [2];
    logic [WIDTH-1:0]         in_data [2];
    logic [1:0]               valid, ready, hv, push, pop;
    logic                     sel, hit;

    assign valid      = {bus.req1_valid, bus.req0_valid};
    assign in_addr[0] = bus.req0_addr;
    assign in_addr[1] = bus.req1_addr;
    assign in_data[0] = bus.req0_data;
    assign in_data[1] = bus.req1_data;

    // Writes to register 0 complete the handshake but are dropped, since r0 is hardwired zero.
    always_comb begin
        ready = '0;
        hv    = '0;
        push  = '0;
        for (int i = 0; i < 2; i++) begin
            ready[i] = cnt[i] != FULL;
            hv[i]    = cnt[i] != '0;
            push[i]  = valid[i] & ready[i] & (|in_addr[i]);
        end
        sel = (hv[0] & hv[1]) ? rr : hv[1];
        pop = (|hv) ? (sel ? 2'b10 : 2'b01) : 2'b00;
    end

    assign bus.req0_ready = ready[0];
    assign bus.req1_ready = ready[1];
    assign bus.we         = |hv;
    assign bus.grant      = sel;
    assign bus.a2         = (|hv) ? q_addr[sel][rp[sel]] : '0;
    assign bus.wd         = (|hv) ? q_data[sel][rp[sel]] : '0;

    // An entry is live when its distance from the read pointer (mod DEPTH) is below the count.
    always_comb begin
        hit = 1'b0;
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < DEPTH; j++)
                hit = hit | ((|bus.query_addr) & ({1'b0, PW'(j) - rp[i]} < cnt[i])
                      & (q_addr[i][j] == bus.query_addr));
    end

    assign bus.query_hit = hit;

    always_ff @(posedge clock) begin
        for (int i = 0; i < 2; i++)
            if (push[i]) begin
                q_addr[i][wp[i]] <= in_addr[i];
                q_data[i][wp[i]] <= in_data[i];
            end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 2; i++) begin
                rp[i]  <= '0;
                wp[i]  <= '0;
                cnt[i] <= '0;
            end
            rr <= 1'b0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (push[i]) wp[i] <= wp[i] + 1'b1;
                if (pop[i]) rp[i] <= rp[i] + 1'b1;
                cnt[i] <= cnt[i] + (PW + 1)'(push[i]) - (PW + 1)'(pop[i]);
            end
            if (|hv) rr <= ~sel;
        end
    end
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb_regfile_write_arbiter: queue-model scoreboard plus directed scenarios for regfile_write_arbiter
module tb_regfile_write_arbiter;
    localparam int DEPTH = 2;

    typedef struct {
        logic [7:0] a;
        logic [7:0] d;
    } ent_t;

    typedef struct {
        int         cyc;
        logic       g;
        logic [7:0] a;
        logic [7:0] d;
    } wr_t;

    logic clock = 1'b0;
    logic reset_n;
    int   total = 0;
    int   bad = 0;

    regfile_write_arbiter_if #(.WIDTH(8), .ADDRESS_WIDTH(8)) bus ();

    regfile_write_arbiter #(.WIDTH(8), .ADDRESS_WIDTH(8), .DEPTH(DEPTH)) dut (
        .clock(clock),
        .reset_n(reset_n),
        .bus(bus)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: one FIFO per requester and a round-robin bit; outputs derived from queue contents.
    ent_t mq0[$];
    ent_t mq1[$];
    bit   mrr;
    wr_t  wlog[$];
    int   cyc = 0;
    bit   e_we, e_g, e_hit;
    ent_t h;

    always @(negedge clock) begin
        if (!reset_n) begin
            mq0.delete();
            mq1.delete();
            mrr = 1'b0;
        end
        e_we = mq0.size() > 0 || mq1.size() > 0;
        e_g  = (mq0.size() > 0 && mq1.size() > 0) ? mrr : (mq1.size() > 0);
        if (e_g && mq1.size() > 0) h = mq1[0];
        else if (mq0.size() > 0) h = mq0[0];
        else h = '{8'h0, 8'h0};
        e_hit = 1'b0;
        foreach (mq0[j]) if (bus.query_addr != 0 && mq0[j].a == bus.query_addr) e_hit = 1'b1;
        foreach (mq1[j]) if (bus.query_addr != 0 && mq1[j].a == bus.query_addr) e_hit = 1'b1;
        chk("m_we", 32'(bus.we), 32'(e_we));
        chk("m_a2", 32'(bus.a2), e_we ? 32'(h.a) : 0);
        chk("m_wd", 32'(bus.wd), e_we ? 32'(h.d) : 0);
        chk("m_hit", 32'(bus.query_hit), 32'(e_hit));
        chk("m_rdy0", 32'(bus.req0_ready), 32'(mq0.size() < DEPTH));
        chk("m_rdy1", 32'(bus.req1_ready), 32'(mq1.size() < DEPTH));
        if (e_we) chk("m_grant", 32'(bus.grant), 32'(e_g));
        if (bus.we === 1'b1) wlog.push_back('{cyc, bus.grant, bus.a2, bus.wd});
        cyc++;
        // Inputs are driven just after a rising edge, so they already hold the values the next edge will see.
        if (reset_n) begin
            bit take0, take1;
            take0 = bus.req0_valid && mq0.size() < DEPTH;
            take1 = bus.req1_valid && mq1.size() < DEPTH;
            if (e_we) begin
                if (e_g) void'(mq1.pop_front());
                else void'(mq0.pop_front());
                mrr = !e_g;
            end
            if (take0 && bus.req0_addr != 0) mq0.push_back('{bus.req0_addr, bus.req0_data});
            if (take1 && bus.req1_addr != 0) mq1.push_back('{bus.req1_addr, bus.req1_data});
        end
    end

    logic [7:0] s0a[$], s0d[$], s1a[$], s1d[$];
    int         acc0[$], acc1[$];
    bit         rdy0[$];

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        wlog.delete();
        acc0.delete();
        acc1.delete();
        rdy0.delete();
        s0a.delete(); s0d.delete(); s1a.delete(); s1d.delete();
    endtask

    // Presents the s0*/s1* lists back to back, advancing on each completed handshake.
    task automatic stream(input int budget);
        int k0 = 0;
        int k1 = 0;
        int t = 0;
        bit r0, r1;
        while ((k0 < s0a.size() || k1 < s1a.size()) && t < budget) begin
            bus.req0_valid = k0 < s0a.size();
            bus.req0_addr  = (k0 < s0a.size()) ? s0a[k0] : 8'h0;
            bus.req0_data  = (k0 < s0d.size()) ? s0d[k0] : 8'h0;
            bus.req1_valid = k1 < s1a.size();
            bus.req1_addr  = (k1 < s1a.size()) ? s1a[k1] : 8'h0;
            bus.req1_data  = (k1 < s1d.size()) ? s1d[k1] : 8'h0;
            r0 = bus.req0_ready;
            r1 = bus.req1_ready;
            rdy0.push_back(r0);
            @(posedge clock);
            t++;
            if (bus.req0_valid && r0) begin acc0.push_back(t); k0++; end
            if (bus.req1_valid && r1) begin acc1.push_back(t); k1++; end
            #1;
        end
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        chk("stream_done", 32'(k0 == s0a.size() && k1 == s1a.size()), 1);
    endtask

    int exp_ca[8] = '{1, 11, 2, 12, 3, 13, 4, 14};
    int exp_acc[3] = '{1, 2, 4};
    bit exp_rdy[4] = '{1, 1, 0, 1};

    initial begin
        int n;
        reset_n = 1'b0;
        bus.req0_valid = 1'b0; bus.req0_addr = '0; bus.req0_data = '0;
        bus.req1_valid = 1'b0; bus.req1_addr = '0; bus.req1_data = '0;
        bus.query_addr = '0;
        repeat (2) @(posedge clock);
        #1;
        reset_n = 1'b1;
        @(negedge clock);
        chk("rst_we", 32'(bus.we), 0);
        chk("rst_a2", 32'(bus.a2), 0);
        chk("rst_rdy0", 32'(bus.req0_ready), 1);
        @(posedge clock);
        #1;

        // single write to r5
        bus.query_addr = 8'd5;
        bus.req0_valid = 1'b1; bus.req0_addr = 8'd5; bus.req0_data = 8'hA5;
        @(negedge clock);
        chk("sw_pre_hit", 32'(bus.query_hit), 0);
        chk("sw_pre_we", 32'(bus.we), 0);
        tick();
        bus.req0_valid = 1'b0;
        @(negedge clock);
        chk("sw_we", 32'(bus.we), 1);
        chk("sw_a2", 32'(bus.a2), 5);
        chk("sw_wd", 32'(bus.wd), 32'hA5);
        chk("sw_grant", 32'(bus.grant), 0);
        chk("sw_hit", 32'(bus.query_hit), 1);
        tick();
        @(negedge clock);
        chk("sw_we_after", 32'(bus.we), 0);
        chk("sw_hit_after", 32'(bus.query_hit), 0);
        tick();

        // contention: both stream 4 writes
        do_reset();
        s0a = '{1, 2, 3, 4};     s0d = '{8'h10, 8'h11, 8'h12, 8'h13};
        s1a = '{11, 12, 13, 14}; s1d = '{8'h20, 8'h21, 8'h22, 8'h23};
        stream(20);
        repeat (6) tick();
        chk("ct_count", 32'(wlog.size()), 8);
        if (wlog.size() == 8)
            for (int k = 0; k < 8; k++) begin
                chk("ct_grant", 32'(wlog[k].g), 32'(k % 2));
                chk("ct_addr", 32'(wlog[k].a), 32'(exp_ca[k]));
                chk("ct_cycle", 32'(wlog[k].cyc), 32'(wlog[0].cyc + k));
            end

        // backpressure: a warm-up r0 write leaves the round-robin pointer on requester 1
        do_reset();
        s0a = '{7}; s0d = '{8'h77};
        stream(10);
        repeat (3) tick();
        wlog.delete(); acc0.delete(); acc1.delete(); rdy0.delete();
        s0a = '{21, 22, 23};             s0d = '{8'h31, 8'h32, 8'h33};
        s1a = '{41, 42, 43, 44, 45, 46}; s1d = '{8'h61, 8'h62, 8'h63, 8'h64, 8'h65, 8'h66};
        stream(30);
        repeat (8) tick();
        chk("bp_acc_n", 32'(acc0.size()), 3);
        if (acc0.size() == 3)
            for (int k = 0; k < 3; k++) chk("bp_acc_edge", 32'(acc0[k]), 32'(exp_acc[k]));
        if (rdy0.size() >= 4)
            for (int k = 0; k < 4; k++) chk("bp_ready", 32'(rdy0[k]), 32'(exp_rdy[k]));
        chk("bp_count", 32'(wlog.size()), 9);
        n = 0;
        foreach (wlog[k])
            if (wlog[k].g == 1'b0) begin
                chk("bp_r0_order", 32'(wlog[k].a), 32'(21 + n));
                n++;
            end
        chk("bp_r0_n", 32'(n), 3);

        // register 0 write is accepted but never written
        do_reset();
        bus.query_addr = 8'd0;
        s1a = '{0}; s1d = '{8'hFF};
        stream(5);
        chk("r0_acc", 32'(acc1.size()), 1);
        repeat (3) tick();
        @(negedge clock);
        chk("r0_hit", 32'(bus.query_hit), 0);
        chk("r0_rdy1", 32'(bus.req1_ready), 1);
        chk("r0_writes", 32'(wlog.size()), 0);
        tick();

        // wrap-around: 10 back-to-back req0 writes
        do_reset();
        for (int k = 0; k < 10; k++) begin
            s0a.push_back(8'(31 + k));
            s0d.push_back(8'(8'h50 + k));
        end
        stream(20);
        repeat (4) tick();
        chk("wr_count", 32'(wlog.size()), 10);
        if (wlog.size() == 10)
            for (int k = 0; k < 10; k++) begin
                chk("wr_addr", 32'(wlog[k].a), 32'(31 + k));
                chk("wr_data", 32'(wlog[k].d), 32'(8'h50 + k));
                chk("wr_cycle", 32'(wlog[k].cyc), 32'(wlog[0].cyc + k));
            end

        // reset with entries queued discards them
        do_reset();
        bus.query_addr = 8'd9;
        bus.req0_valid = 1'b1; bus.req0_addr = 8'd9;  bus.req0_data = 8'h99;
        bus.req1_valid = 1'b1; bus.req1_addr = 8'd10; bus.req1_data = 8'hAA;
        tick();
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        reset_n = 1'b0;
        @(negedge clock);
        chk("mr_we", 32'(bus.we), 0);
        chk("mr_hit", 32'(bus.query_hit), 0);
        chk("mr_rdy0", 32'(bus.req0_ready), 1);
        chk("mr_rdy1", 32'(bus.req1_ready), 1);
        tick();
        reset_n = 1'b1;
        repeat (3) tick();
        chk("mr_writes", 32'(wlog.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end
endmodule
